key_judge_initiator: RTL and testbench

- Initiating end of the go/done drawing handshake: watches the four active-low game keys and debounces them.
- Encodes the pressed key to a line id and compares it against the lane of the tile in the hit zone.
- Drives either the correct-input or the incorrect-input draw request, then holds it until the matching done arrives.
- Keeps score and strike count and asserts game over; sits between the board keys and the block-drawing responders.

---
 rtl/key_judge_initiator.sv | 183 ++++++++++++++++++
 tb/tb_key_judge_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_judge_initiator.sv
// key_judge_initiator: debounces the four active-low game keys, judges the
// accepted key against the lane in the hit zone, raises the matching draw
// request and holds it until its done returns, and tracks score, strikes
// and game over.
module key_judge_initiator #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_STRIKES     = 3,
  parameter int SCORE_MAX       = 999
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key3,
  input  logic       key2,
  input  logic       key1,
  input  logic       key0,
  input  logic [2:0] expected_line,
  input  logic       correct_input_done,
  input  logic       incorrect_input_done,
  output logic       correct_input_go,
  output logic       incorrect_input_go,
  output logic [2:0] hit_line,
  output logic       tile_consumed,
  output logic [9:0] score,
  output logic [1:0] strikes,
  output logic       game_over
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The IDLE cycle that spots the press is the first stable sample, so the
  // press side exits one count earlier than the release side.
  localparam logic [CW-1:0] PRESS_LAST   = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]    SCORE_TOP    = 10'(SCORE_MAX);
  localparam logic [1:0]    STRIKE_TOP   = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_JUDGE, S_DRAW_OK, S_DRAW_BAD, S_WAIT_RELEASE, S_GAME_OVER
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_cand, w_cand_nxt;
  logic [2:0]      r_hit, w_hit_nxt;
  logic [9:0]      r_score, w_score_nxt;
  logic [1:0]      r_strikes, w_strikes_nxt;
  logic            r_ok_go, w_ok_go_nxt;
  logic            r_bad_go, w_bad_go_nxt;
  logic [2:0]      w_line;
  logic            w_all_up;
  logic            w_match;
  logic            w_consume;

  function automatic logic [9:0] sat_score(input logic [9:0] v);
    return (v >= SCORE_TOP) ? SCORE_TOP : v + 10'd1;
  endfunction

  function automatic logic [1:0] sat_strikes(input logic [1:0] v);
    return (v >= STRIKE_TOP) ? STRIKE_TOP : v + 2'd1;
  endfunction

  // Fixed-priority key encoder: key3 wins over key2 over key1 over key0.
  always_comb begin
    w_line = 3'd0;
    if (!key3)      w_line = 3'd1;
    else if (!key2) w_line = 3'd2;
    else if (!key1) w_line = 3'd3;
    else if (!key0) w_line = 3'd4;
  end

  assign w_all_up = key3 & key2 & key1 & key0;
  assign w_match  = (expected_line == r_hit) && (expected_line != 3'd0);

  // Next-state and next-register computation for the judge FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cand_nxt    = r_cand;
    w_hit_nxt     = r_hit;
    w_score_nxt   = r_score;
    w_strikes_nxt = r_strikes;
    w_ok_go_nxt   = r_ok_go;
    w_bad_go_nxt  = r_bad_go;
    w_consume     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_line != 3'd0) begin
          w_cand_nxt  = w_line;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (w_line != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == PRESS_LAST) begin
          w_cnt_nxt   = '0;
          w_hit_nxt   = r_cand;
          w_state_nxt = S_JUDGE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_JUDGE: begin
        if (w_match) begin
          w_consume   = 1'b1;
          w_score_nxt = sat_score(r_score);
          w_ok_go_nxt = 1'b1;
          w_state_nxt = S_DRAW_OK;
        end else begin
          w_strikes_nxt = sat_strikes(r_strikes);
          w_bad_go_nxt  = 1'b1;
          w_state_nxt   = S_DRAW_BAD;
        end
      end
      S_DRAW_OK: begin
        if (correct_input_done) begin
          w_ok_go_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_RELEASE;
        end
      end
      S_DRAW_BAD: begin
        if (incorrect_input_done) begin
          w_bad_go_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = (r_strikes == STRIKE_TOP) ? S_GAME_OVER : S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!w_all_up) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == RELEASE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAME_OVER: begin
        w_ok_go_nxt  = 1'b0;
        w_bad_go_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counter, latched lines, score/strike counters and the go requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_cand    <= 3'd0;
      r_hit     <= 3'd0;
      r_score   <= 10'd0;
      r_strikes <= 2'd0;
      r_ok_go   <= 1'b0;
      r_bad_go  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      r_hit     <= w_hit_nxt;
      r_score   <= w_score_nxt;
      r_strikes <= w_strikes_nxt;
      r_ok_go   <= w_ok_go_nxt;
      r_bad_go  <= w_bad_go_nxt;
    end
  end

  assign correct_input_go   = r_ok_go;
  assign incorrect_input_go = r_bad_go;
  assign hit_line           = r_hit;
  assign tile_consumed      = w_consume;
  assign score              = r_score;
  assign strikes            = r_strikes;
  assign game_over          = (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_key_judge_initiator.sv
// Directed bench for key_judge_initiator with a short debounce window.
module tb_key_judge_initiator;

  logic       clock = 1'b0;
  logic       reset;
  logic       key3, key2, key1, key0;
  logic [2:0] expected_line;
  logic       correct_input_done, incorrect_input_done;
  logic       correct_input_go, incorrect_input_go;
  logic [2:0] hit_line;
  logic       tile_consumed;
  logic [9:0] score;
  logic [1:0] strikes;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  key_judge_initiator #(
    .DEBOUNCE_CYCLES(4),
    .MAX_STRIKES    (3),
    .SCORE_MAX      (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .key3                (key3),
    .key2                (key2),
    .key1                (key1),
    .key0                (key0),
    .expected_line       (expected_line),
    .correct_input_done  (correct_input_done),
    .incorrect_input_done(incorrect_input_done),
    .correct_input_go    (correct_input_go),
    .incorrect_input_go  (incorrect_input_go),
    .hit_line            (hit_line),
    .tile_consumed       (tile_consumed),
    .score               (score),
    .strikes             (strikes),
    .game_over           (game_over)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    n_cmp++; if (correct_input_go !== 1'b0) begin n_bad++; $display("FAIL rst_cgo got %b want 0", correct_input_go); end
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL rst_igo got %b want 0", incorrect_input_go); end
    n_cmp++; if (hit_line !== 3'd0) begin n_bad++; $display("FAIL rst_hit got %0d want 0", hit_line); end
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL rst_tile got %b want 0", tile_consumed); end
    n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL rst_score got %0d want 0", score); end
    n_cmp++; if (strikes !== 2'd0) begin n_bad++; $display("FAIL rst_strikes got %0d want 0", strikes); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL rst_gameover got %b want 0", game_over); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_correct_hit;
    expected_line = 3'd3;
    key1 = 1'b0;
    tick(3);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL hit_early_tile got %b want 0", tile_consumed); end
    tick(1);
    n_cmp++; if (tile_consumed !== 1'b1) begin n_bad++; $display("FAIL hit_judge_tile got %b want 1", tile_consumed); end
    n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL hit_score_pre got %0d want 0", score); end
    tick(1);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL hit_tile_pulse got %b want 0", tile_consumed); end
    n_cmp++; if (score !== 10'd1) begin n_bad++; $display("FAIL hit_score got %0d want 1", score); end
    n_cmp++; if (correct_input_go !== 1'b1) begin n_bad++; $display("FAIL hit_cgo got %b want 1", correct_input_go); end
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL hit_igo got %b want 0", incorrect_input_go); end
    n_cmp++; if (hit_line !== 3'd3) begin n_bad++; $display("FAIL hit_line got %0d want 3", hit_line); end
    tick(4);
    n_cmp++; if (correct_input_go !== 1'b1) begin n_bad++; $display("FAIL hit_cgo_hold got %b want 1", correct_input_go); end
    n_cmp++; if (hit_line !== 3'd3) begin n_bad++; $display("FAIL hit_line_hold got %0d want 3", hit_line); end
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    key1 = 1'b1;
    n_cmp++; if (correct_input_go !== 1'b0) begin n_bad++; $display("FAIL hit_cgo_fall got %b want 0", correct_input_go); end
    tick(6);
  endtask

  task automatic test_bounce;
    int pulses;
    pulses = 0;
    expected_line = 3'd2;
    key2 = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(1); pulses += int'(tile_consumed); end
    key2 = 1'b1;
    tick(1); pulses += int'(tile_consumed);
    key2 = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(1); pulses += int'(tile_consumed); end
    tick(1); pulses += int'(tile_consumed);
    n_cmp++; if (correct_input_go !== 1'b1) begin n_bad++; $display("FAIL bounce_cgo got %b want 1", correct_input_go); end
    n_cmp++; if (hit_line !== 3'd2) begin n_bad++; $display("FAIL bounce_hit got %0d want 2", hit_line); end
    n_cmp++; if (score !== 10'd2) begin n_bad++; $display("FAIL bounce_score got %0d want 2", score); end
    key2 = 1'b1;
    correct_input_done = 1'b1;
    tick(1); pulses += int'(tile_consumed);
    correct_input_done = 1'b0;
    n_cmp++; if (correct_input_go !== 1'b0) begin n_bad++; $display("FAIL bounce_cgo_fall got %b want 0", correct_input_go); end
    for (int i = 0; i < 6; i++) begin tick(1); pulses += int'(tile_consumed); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL bounce_judgements got %0d want 1", pulses); end
    n_cmp++; if (strikes !== 2'd0) begin n_bad++; $display("FAIL bounce_strikes got %0d want 0", strikes); end
  endtask

  task automatic test_wrong_key;
    expected_line = 3'd1;
    key0 = 1'b0;
    tick(4);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL wrong_tile got %b want 0", tile_consumed); end
    correct_input_done = 1'b1;
    tick(1);
    n_cmp++; if (incorrect_input_go !== 1'b1) begin n_bad++; $display("FAIL wrong_igo got %b want 1", incorrect_input_go); end
    n_cmp++; if (correct_input_go !== 1'b0) begin n_bad++; $display("FAIL wrong_cgo got %b want 0", correct_input_go); end
    n_cmp++; if (hit_line !== 3'd4) begin n_bad++; $display("FAIL wrong_hit got %0d want 4", hit_line); end
    n_cmp++; if (strikes !== 2'd1) begin n_bad++; $display("FAIL wrong_strikes got %0d want 1", strikes); end
    n_cmp++; if (score !== 10'd2) begin n_bad++; $display("FAIL wrong_score got %0d want 2", score); end
    tick(3);
    n_cmp++; if (incorrect_input_go !== 1'b1) begin n_bad++; $display("FAIL wrong_other_done got %b want 1", incorrect_input_go); end
    correct_input_done = 1'b0;
    incorrect_input_done = 1'b1;
    key0 = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL wrong_igo_fall got %b want 0", incorrect_input_go); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL wrong_gameover got %b want 0", game_over); end
    tick(6);
  endtask

  task automatic test_simultaneous_hold;
    int activity;
    activity = 0;
    expected_line = 3'd4;
    key3 = 1'b0;
    key0 = 1'b0;
    tick(5);
    n_cmp++; if (incorrect_input_go !== 1'b1) begin n_bad++; $display("FAIL simul_igo got %b want 1", incorrect_input_go); end
    n_cmp++; if (hit_line !== 3'd1) begin n_bad++; $display("FAIL simul_hit got %0d want 1", hit_line); end
    n_cmp++; if (strikes !== 2'd2) begin n_bad++; $display("FAIL simul_strikes got %0d want 2", strikes); end
    incorrect_input_done = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL simul_igo_fall got %b want 0", incorrect_input_go); end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      activity += int'(correct_input_go | incorrect_input_go | tile_consumed);
    end
    n_cmp++; if (activity !== 0) begin n_bad++; $display("FAIL hold_second_judge got %0d active cycles want 0", activity); end
    n_cmp++; if (strikes !== 2'd2) begin n_bad++; $display("FAIL hold_strikes got %0d want 2", strikes); end
    key3 = 1'b1;
    key0 = 1'b1;
    tick(4);
    expected_line = 3'd1;
    key3 = 1'b0;
    tick(3);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL release_early_tile got %b want 0", tile_consumed); end
    tick(1);
    n_cmp++; if (tile_consumed !== 1'b1) begin n_bad++; $display("FAIL release_idle_tile got %b want 1", tile_consumed); end
    tick(1);
    n_cmp++; if (correct_input_go !== 1'b1) begin n_bad++; $display("FAIL sat_cgo got %b want 1", correct_input_go); end
    n_cmp++; if (score !== 10'd2) begin n_bad++; $display("FAIL sat_score got %0d want 2", score); end
    correct_input_done = 1'b1;
    key3 = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    tick(6);
  endtask

  task automatic test_game_over;
    int activity;
    activity = 0;
    expected_line = 3'd0;
    key2 = 1'b0;
    tick(4);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL go_empty_tile got %b want 0", tile_consumed); end
    tick(1);
    n_cmp++; if (incorrect_input_go !== 1'b1) begin n_bad++; $display("FAIL go_igo got %b want 1", incorrect_input_go); end
    n_cmp++; if (hit_line !== 3'd2) begin n_bad++; $display("FAIL go_hit got %0d want 2", hit_line); end
    n_cmp++; if (strikes !== 2'd3) begin n_bad++; $display("FAIL go_strikes got %0d want 3", strikes); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL go_early got %b want 0", game_over); end
    incorrect_input_done = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL go_igo_fall got %b want 0", incorrect_input_go); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL go_flag got %b want 1", game_over); end
    key2 = 1'b1;
    tick(6);
    expected_line = 3'd3;
    key1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      activity += int'(correct_input_go | incorrect_input_go | tile_consumed);
    end
    key1 = 1'b1;
    n_cmp++; if (activity !== 0) begin n_bad++; $display("FAIL go_keys_ignored got %0d active cycles want 0", activity); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL go_sticky got %b want 1", game_over); end
    n_cmp++; if (strikes !== 2'd3) begin n_bad++; $display("FAIL go_strikes_hold got %0d want 3", strikes); end
  endtask

  task automatic test_reset_mid_handshake;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL mid_gameover_clear got %b want 0", game_over); end
    expected_line = 3'd1;
    key0 = 1'b0;
    tick(5);
    n_cmp++; if (incorrect_input_go !== 1'b1) begin n_bad++; $display("FAIL mid_igo got %b want 1", incorrect_input_go); end
    n_cmp++; if (strikes !== 2'd1) begin n_bad++; $display("FAIL mid_strikes got %0d want 1", strikes); end
    reset = 1'b1;
    #1;
    n_cmp++; if (incorrect_input_go !== 1'b0) begin n_bad++; $display("FAIL async_igo got %b want 0", incorrect_input_go); end
    n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL async_score got %0d want 0", score); end
    n_cmp++; if (strikes !== 2'd0) begin n_bad++; $display("FAIL async_strikes got %0d want 0", strikes); end
    n_cmp++; if (hit_line !== 3'd0) begin n_bad++; $display("FAIL async_hit got %0d want 0", hit_line); end
    tick(1);
    key0 = 1'b1;
    reset = 1'b0;
    tick(1);
    expected_line = 3'd3;
    key1 = 1'b0;
    tick(3);
    n_cmp++; if (tile_consumed !== 1'b0) begin n_bad++; $display("FAIL post_rst_early got %b want 0", tile_consumed); end
    tick(1);
    n_cmp++; if (tile_consumed !== 1'b1) begin n_bad++; $display("FAIL post_rst_idle got %b want 1", tile_consumed); end
    tick(1);
    n_cmp++; if (score !== 10'd1) begin n_bad++; $display("FAIL post_rst_score got %0d want 1", score); end
    n_cmp++; if (correct_input_go !== 1'b1) begin n_bad++; $display("FAIL post_rst_cgo got %b want 1", correct_input_go); end
    correct_input_done = 1'b1;
    key1 = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    key3 = 1'b1; key2 = 1'b1; key1 = 1'b1; key0 = 1'b1;
    expected_line = 3'd0;
    correct_input_done = 1'b0;
    incorrect_input_done = 1'b0;
    test_reset();
    test_correct_hit();
    test_bounce();
    test_wrong_key();
    test_simultaneous_hold();
    test_game_over();
    test_reset_mid_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
